// File: rtl/in_out_sram_ctrl.sv
// Burst initiator for the input/output SRAM port. Write bursts stream straight into the SRAM;
// read bursts pass through a 3-entry FIFO so the output keeps one word per cycle under backpressure.
module in_out_sram_ctrl #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // Command
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [LEN_WIDTH-1:0]  cmd_len_i,
   // Write-data stream
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   // Read-data stream
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   // SRAM port
   output logic                  sram_req_o,
   output logic                  sram_we_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i,
   // Status
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned FifoDepth = 3;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  inflight_q;
   logic [1:0]            occ_q, occ_d;
   logic [1:0]            wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] fifo_q [FifoDepth];
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  drain_empty;

   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
   endfunction

   // A read is only issued if its data is guaranteed a FIFO slot on arrival.
   assign issue = (state_q == StRead) && (rem_q != '0) &&
                  (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);

   assign push      = inflight_q;
   assign m_valid_o = (occ_q != 2'd0);
   assign pop       = m_valid_o && m_ready_i;
   assign m_data_o  = m_valid_o ? fifo_q[rd_ptr_q] : '0;

   // The FIFO is empty after this cycle once nothing is in flight and the last word leaves.
   assign drain_empty = !inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));

   assign cmd_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);
   assign sram_addr_o = addr_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      s_ready_o    = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_wdata_o = '0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               addr_d = cmd_addr_i;
               rem_d  = cmd_len_i;
               if (cmd_len_i == '0) begin
                  state_d = StDone;
               end else if (cmd_write_i) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StWrite: begin
            s_ready_o    = 1'b1;
            sram_req_o   = s_valid_i;
            sram_we_o    = s_valid_i;
            sram_wdata_o = s_data_i;
            if (s_valid_i) begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - LEN_WIDTH'(1);
               if (rem_q == LEN_WIDTH'(1)) begin
                  state_d = StDone;
               end
            end
         end
         StRead: begin
            if (issue) begin
               sram_req_o = 1'b1;
               addr_d     = addr_q + ADDR_WIDTH'(1);
               rem_d      = rem_q - LEN_WIDTH'(1);
               if (rem_q == LEN_WIDTH'(1)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (drain_empty) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= issue;
         occ_q      <= occ_d;
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
      end
   end

   // Storage needs no reset; occupancy alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         fifo_q[wr_ptr_q] <= sram_rdata_i;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (occ_q == 2'd3)));

   a_we_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
      !(sram_we_o && (state_q != StWrite)));

endmodule

// File: doc/in_out_sram_ctrl.md
# in_out_sram_ctrl

Burst initiator for the 8 KB input/output SRAM port (req/we/addr/wdata/rdata, one-cycle registered read data). It accepts a command (direction, start address, word count) and either streams words from a valid/ready input into consecutive SRAM locations, or reads consecutive locations and streams them out on a valid/ready output. Read backpressure is absorbed by a 3-entry output FIFO, so the output stream sustains one word per cycle. It sits between the Octree wrapper's data movers and the SRAM.

## Interface
- ADDR_WIDTH, 10, SRAM word address width.
- DATA_WIDTH, 64, word width.
- LEN_WIDTH, ADDR_WIDTH+1, burst length field width (max 1024 words).
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_write_i  in  1  1 = stream-to-SRAM write, 0 = SRAM-to-stream read.
- cmd_addr_i  in  ADDR_WIDTH  start word address.
- cmd_len_i  in  LEN_WIDTH  word count; 0 is legal.
- s_valid_i / s_ready_o  in/out  1  write-data stream handshake.
- s_data_i  in  DATA_WIDTH  write data.
- m_valid_o / m_ready_i  out/in  1  read-data stream handshake.
- m_data_o  out  DATA_WIDTH  read data.
- sram_req_o, sram_we_o  out  1  SRAM chip enable and write enable.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read request.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: cmd_ready_o=1. On cmd handshake, latch addr, len, and dir. If len==0, go to DONE. Otherwise go to WRITE or READ.
- WRITE: s_ready_o=1. sram_req_o=sram_we_o=s_valid_i, combinationally. sram_addr_o=addr_q and sram_wdata_o=s_data_i. Each handshake increments addr_q and decrements the remaining count. After the last beat, go to DONE.
- READ: issue condition is remaining>0 and occ+inflight<3.
  - occ is the FIFO occupancy (0..3). inflight is 1 if a read was issued in the previous cycle.
  - When the condition holds, sram_req_o=1, sram_we_o=0, sram_addr_o=addr_q. addr_q increments and remaining decrements.
  - inflight data is pushed into the FIFO the following cycle.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: wait for inflight==0 and occ==0 (last word popped), then go to DONE.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
- m_valid_o=(occ!=0). m_data_o is the FIFO head. Pop on m_valid_o & m_ready_i. Push and pop may occur in the same cycle.
- The address wraps modulo 2^ADDR_WIDTH: 0x3FF+1 → 0x000.
- Signals outside their active state:
  - sram_we_o=0 outside WRITE.
  - sram_wdata_o=0 outside WRITE.
  - s_ready_o=0 outside WRITE.
  - s_data_i is ignored outside WRITE.
- Reset:
  - Any cycle with rst_n=0 at the clock edge forces IDLE, clears the FIFO, inflight, addr_q and remaining, and aborts any burst.
  - Data from an in-flight read is discarded.
  - After reset, all outputs are 0 except cmd_ready_o=1.

## Timing
- Command accepted in cycle C; the state is active from C+1. busy_o rises at C+1.
- Write: a beat handshaken in cycle N drives the SRAM write in cycle N, so latency is zero. With s_valid_i held high, len words take cycles C+1..C+len. done_o fires one cycle after the last beat.
- Read: first sram_req_o at C+1, rdata at C+2, pushed at the C+2 edge, m_valid_o=1 at C+3. With m_ready_i=1 throughout, one word is delivered per cycle; len words occupy C+3..C+len+2 and done_o fires at C+len+3.
- With m_ready_i=0, requests stop once occ+inflight=3, and no SRAM read is ever issued without FIFO space.
- m_data_o and m_valid_o are stable while m_valid_o & !m_ready_i.
- Zero-length command: DONE at C+1, IDLE at C+2, with no SRAM or stream activity.
- cmd_ready_o=0 from C+1 until IDLE is re-entered, i.e. one cycle after done_o.

## Test plan
- Write 4 words at addr 0x010, data 0xA0..0xA3, s_valid_i always high → SRAM writes at 0x010..0x013 in consecutive cycles; done_o one cycle after the 4th beat.
- Read 4 words at 0x010 with m_ready_i=1 → m_data_o outputs 0xA0..0xA3 on consecutive cycles starting at C+3; done_o at C+7.
- Read 8 words with m_ready_i=0 for 10 cycles, then 1 → exactly 3 reads are issued before stalling; all 8 words are delivered in order, none lost or duplicated.
- Write 3 words at 0x3FE → addresses 0x3FE, 0x3FF, 0x000; reading the same burst back returns the same data.
- Command with len=0 → done_o at C+1, sram_req_o never asserted, cmd_ready_o=1 at C+2.
- Assert rst_n=0 for one cycle mid-read with 2 words buffered → m_valid_o=0 and cmd_ready_o=1 the next cycle; no further sram_req_o; a new command then works normally.
